// File: rtl/servo_bank.sv
// Multi-channel servo PWM bank: one shared frame counter, saturating magnitude-to-width
// mapping, per-channel slew limiting, frame-aligned enable and global width hold.
module servo_bank #(
   parameter int NCH         = 16,
   parameter int MAG_W       = 64,
   parameter int FRAME_TICKS = 1_000_000,
   parameter int MIN_TICKS   = 50_000,
   parameter int RANGE_TICKS = 50_000,
   parameter int SHIFT       = 0,
   parameter int SLEW_TICKS  = 2_500
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [MAG_W-1:0] magnitude [0:NCH-1],
   input  logic             mag_valid,
   input  logic [NCH-1:0]   chan_en,
   input  logic             hold,
   output logic [NCH-1:0]   pulse_out,
   output logic             frame_start
);

   localparam int CW = $clog2(FRAME_TICKS);
   localparam int XW = (MAG_W > CW) ? MAG_W : CW;
   localparam logic [CW-1:0] LAST    = CW'(FRAME_TICKS - 1);
   localparam logic [CW-1:0] MIN_C   = CW'(MIN_TICKS);
   localparam logic [CW-1:0] RANGE_C = CW'(RANGE_TICKS);
   localparam logic [XW-1:0] RANGE_X = XW'(RANGE_TICKS);
   localparam logic [CW-1:0] SLEW_C  = CW'(SLEW_TICKS);

   generate
      if (MIN_TICKS + RANGE_TICKS >= FRAME_TICKS) begin : g_bad_range
         $error("servo_bank: MIN_TICKS + RANGE_TICKS must be below FRAME_TICKS");
      end
      if (NCH < 1) begin : g_bad_nch
         $error("servo_bank: NCH must be at least 1");
      end
   endgenerate

   logic [CW-1:0]  cnt;
   logic [CW-1:0]  target     [NCH];
   logic [CW-1:0]  width      [NCH];
   logic [CW-1:0]  target_nxt [NCH];
   logic [CW-1:0]  width_nxt  [NCH];
   logic [XW-1:0]  mag_sh     [NCH];
   logic [NCH-1:0] en_q;
   logic           primed;
   logic           boundary;

   assign boundary = (cnt == LAST);

   // Saturation compare is done at the wider of MAG_W and the counter width so huge words clamp.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         mag_sh[i]     = XW'(magnitude[i] >> SHIFT);
         target_nxt[i] = MIN_C + ((mag_sh[i] > RANGE_X) ? RANGE_C : mag_sh[i][CW-1:0]);
         width_nxt[i]  = target[i];
         if (SLEW_TICKS != 0) begin
            if (target[i] > width[i]) begin
               if (target[i] - width[i] > SLEW_C) width_nxt[i] = width[i] + SLEW_C;
            end else begin
               if (width[i] - target[i] > SLEW_C) width_nxt[i] = width[i] - SLEW_C;
            end
         end
      end
   end

   // primed keeps frame_start quiet in the first frame after reset, before en_q has been sampled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt         <= '0;
         en_q        <= '0;
         primed      <= 1'b0;
         pulse_out   <= '0;
         frame_start <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            target[i] <= MIN_C;
            width[i]  <= MIN_C;
         end
      end else begin
         cnt         <= boundary ? '0 : cnt + 1'b1;
         frame_start <= (cnt == '0) && primed;
         for (int i = 0; i < NCH; i++) begin
            pulse_out[i] <= en_q[i] && (cnt < width[i]);
            if (mag_valid) target[i] <= target_nxt[i];
            if (boundary && !hold) width[i] <= width_nxt[i];
         end
         if (boundary) begin
            en_q   <= chan_en;
            primed <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_servo_bank.sv
// Frame-level bench for servo_bank: two instances (slew 10 and slew 0) measured per frame
// against a per-frame width/enable model.
module tb_servo_bank;

   localparam int NCH = 4;
   localparam int MW  = 16;
   localparam int FT  = 1000;
   localparam int MN  = 100;
   localparam int RG  = 100;
   localparam int SL  = 10;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [MW-1:0]  magnitude [0:NCH-1];
   logic           mag_valid = 1'b0;
   logic [NCH-1:0] chan_en = '0;
   logic           hold = 1'b0;
   logic [NCH-1:0] pulse_a, pulse_b;
   logic           fs_a, fs_b;

   always #5 clk = ~clk;

   servo_bank #(.NCH(NCH), .MAG_W(MW), .FRAME_TICKS(FT), .MIN_TICKS(MN),
                .RANGE_TICKS(RG), .SHIFT(0), .SLEW_TICKS(SL)) dut_a (
      .clk(clk), .reset_n(reset_n), .magnitude(magnitude), .mag_valid(mag_valid),
      .chan_en(chan_en), .hold(hold), .pulse_out(pulse_a), .frame_start(fs_a));

   servo_bank #(.NCH(NCH), .MAG_W(MW), .FRAME_TICKS(FT), .MIN_TICKS(MN),
                .RANGE_TICKS(RG), .SHIFT(0), .SLEW_TICKS(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .magnitude(magnitude), .mag_valid(mag_valid),
      .chan_en(chan_en), .hold(hold), .pulse_out(pulse_b), .frame_start(fs_b));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: per-frame widths for both slew settings, shared targets, sampled enables.
   int tgt [NCH];
   int wid [2][NCH];
   bit en_m [NCH];
   bit primed;
   int slew_of [2] = '{SL, 0};
   int frame_no = 0;

   int mv_pos = -1;
   int mv_mag [NCH];
   int en_pos = -1;
   logic [NCH-1:0] en_new;

   function automatic int target_of(int mag);
      return MN + ((mag > RG) ? RG : mag);
   endfunction

   function automatic int step(int w, int t, int s);
      int d = t - w;
      if (s == 0) return t;
      if (d > s) d = s;
      else if (d < -s) d = -s;
      return w + d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         tgt[i] = MN;
         wid[0][i] = MN;
         wid[1][i] = MN;
         en_m[i] = 1'b0;
      end
      primed = 1'b0;
   endtask

   task automatic load_targets();
      for (int i = 0; i < NCH; i++) tgt[i] = target_of(mv_mag[i]);
   endtask

   // Starts at a negedge just before the edge on which the DUT counter is 0.
   task automatic run_frame();
      int hi [2][NCH];
      int fsn [2];
      logic [NCH-1:0] first [2];
      logic fs0 [2];
      logic [NCH-1:0] po [2];
      logic fsv [2];
      int ew;
      for (int m = 0; m < 2; m++) begin
         fsn[m] = 0;
         first[m] = '0;
         fs0[m] = 1'b0;
         for (int i = 0; i < NCH; i++) hi[m][i] = 0;
      end
      for (int p = 0; p < FT; p++) begin
         mag_valid = (p == mv_pos);
         if (p == mv_pos)
            for (int i = 0; i < NCH; i++) magnitude[i] = MW'(mv_mag[i]);
         if (p == en_pos) chan_en = en_new;
         @(negedge clk);
         po[0] = pulse_a;  po[1] = pulse_b;
         fsv[0] = fs_a;    fsv[1] = fs_b;
         for (int m = 0; m < 2; m++) begin
            if (fsv[m]) fsn[m]++;
            if (p == 0) begin
               first[m] = po[m];
               fs0[m] = fsv[m];
            end
            for (int i = 0; i < NCH; i++) if (po[m][i]) hi[m][i]++;
         end
      end
      mag_valid = 1'b0;
      for (int m = 0; m < 2; m++) begin
         check($sformatf("f%0d d%0d frame_start_count", frame_no, m), fsn[m], primed ? 1 : 0);
         check($sformatf("f%0d d%0d frame_start_first", frame_no, m), fs0[m], primed ? 1 : 0);
         for (int i = 0; i < NCH; i++) begin
            ew = en_m[i] ? wid[m][i] : 0;
            check($sformatf("f%0d d%0d ch%0d high_cycles", frame_no, m, i), hi[m][i], ew);
            check($sformatf("f%0d d%0d ch%0d rise_aligned", frame_no, m, i), first[m][i], ew > 0);
         end
      end
      if (mv_pos >= 0 && mv_pos < FT - 1) load_targets();
      if (!hold)
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < NCH; i++) wid[m][i] = step(wid[m][i], tgt[i], slew_of[m]);
      if (mv_pos == FT - 1) load_targets();
      for (int i = 0; i < NCH; i++) en_m[i] = chan_en[i];
      primed = 1'b1;
      frame_no++;
      mv_pos = -1;
      en_pos = -1;
   endtask

   task automatic set_mags(input int a, input int b, input int c, input int d, input int pos);
      mv_mag[0] = a; mv_mag[1] = b; mv_mag[2] = c; mv_mag[3] = d;
      mv_pos = pos;
   endtask

   task automatic reset_mid(input int at);
      for (int p = 0; p < at - 1; p++) @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
         check($sformatf("pre_reset ch%0d", i), pulse_a[i], en_m[i] && (at - 1 < wid[0][i]));
      reset_n = 1'b0;
      @(negedge clk);
      check("reset pulse_a", pulse_a, 0);
      check("reset pulse_b", pulse_b, 0);
      check("reset fs_a", fs_a, 0);
      check("reset fs_b", fs_b, 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      frame_no = 0;
   endtask

   int r;

   initial begin
      for (int i = 0; i < NCH; i++) magnitude[i] = '0;
      model_reset();
      chan_en = 4'hF;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      run_frame();
      run_frame();
      set_mags(50, 16'hFFFF, 73, 80, 300);
      run_frame();
      repeat (8) run_frame();
      en_new = 4'h7; en_pos = 150;
      run_frame();
      run_frame();
      en_new = 4'hF; en_pos = 500;
      run_frame();
      set_mags(0, 0, 0, 40, 10);
      run_frame();
      run_frame();
      hold = 1'b1;
      run_frame();
      run_frame();
      hold = 1'b0;
      run_frame();
      run_frame();
      set_mags(200, 30, 90, 0, FT - 1);
      run_frame();
      repeat (3) run_frame();

      for (int k = 0; k < 16; k++) begin
         r = $urandom_range(0, 3);
         if (r == 0) mv_pos = -1;
         else if (r == 1) mv_pos = FT - 1;
         else mv_pos = $urandom_range(0, FT - 2);
         for (int i = 0; i < NCH; i++) begin
            case ($urandom_range(0, 3))
               0: mv_mag[i] = $urandom_range(0, 100);
               1: mv_mag[i] = $urandom_range(101, 300);
               2: mv_mag[i] = 16'hFFFF;
               default: mv_mag[i] = $urandom_range(0, 65535);
            endcase
         end
         en_pos = $urandom_range(0, FT - 1);
         en_new = NCH'($urandom);
         hold = ($urandom_range(0, 4) == 0);
         run_frame();
      end
      hold = 1'b0;
      chan_en = 4'hF;
      run_frame();
      run_frame();
      reset_mid(120);
      run_frame();
      run_frame();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
